vsm_sequencer: RTL

// Upstream control stage for vsm. Holds an N-column weight matrix; each column is SIZE lanes of 8 bits.

---
 rtl/vsm_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vsm_sequencer.sv
// Control stage in front of a vsm multiply-accumulate unit: holds an N-column weight matrix
// and streams (column j, element j) pairs into vsm, then presents y = W * x on a valid/ready port.
module vsm_sequencer #(
    parameter int SIZE    = 3,
    parameter int N       = 3,
    parameter int VSM_LAT = 1,
    localparam int AW     = (N > 1) ? $clog2(N) : 1,
    localparam int CW     = $clog2(((N > VSM_LAT) ? N : VSM_LAT) + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic [8*SIZE-1:0]   w_data,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic [8*N-1:0]      x_data,
    output logic                y_valid,
    input  logic                y_ready,
    output logic [8*SIZE-1:0]   y_data,
    output logic                busy,
    output logic                vsm_reset,
    output logic                vsm_enable,
    output logic [8*SIZE-1:0]   vsm_a,
    output logic [7:0]          vsm_b,
    input  logic [8*SIZE-1:0]   vsm_out
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_MAC,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       j_q, j_d;
    logic [8*N-1:0]      x_q, x_d;
    logic [8*SIZE-1:0]   y_data_q, y_data_d;
    logic [8*SIZE-1:0]   mem_q [N];
    logic [7:0]          x_elem [N];
    logic                w_accept;

    // NOTE: the weight array has no reset; only the control path is cleared, and
    // leaving the storage out of reset lets it map onto plain RAM/register files.
    assign w_accept = w_we && !reset && (state_q == ST_IDLE)
                      && ({1'b0, w_addr} < (AW+1)'(N));

    always_ff @(posedge clk) begin
        if (w_accept) begin
            mem_q[w_addr] <= w_data;
        end
    end

    // Element 0 sits in the MSBs of the latched vector.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            x_elem[k] = x_q[8*(N-k)-1 -: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            j_q      <= '0;
            x_q      <= '0;
            y_data_q <= '0;
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            x_q      <= x_d;
            y_data_q <= y_data_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        x_d        = x_q;
        y_data_d   = y_data_q;
        x_ready    = 1'b0;
        y_valid    = 1'b0;
        vsm_reset  = reset;
        vsm_enable = 1'b0;
        vsm_a      = '0;
        vsm_b      = '0;

        unique case (state_q)
            ST_IDLE: begin
                x_ready = !reset;
                if (x_valid && !reset) begin
                    x_d     = x_data;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                vsm_reset = 1'b1;
                j_d       = '0;
                state_d   = ST_MAC;
            end
            ST_MAC: begin
                vsm_enable = 1'b1;
                vsm_a      = mem_q[j_q[AW-1:0]];
                vsm_b      = x_elem[j_q[AW-1:0]];
                if (j_q == CW'(N-1)) begin
                    j_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // vsm_out settles VSM_LAT cycles after the last enable.
                if (j_q == CW'(VSM_LAT-1)) begin
                    y_data_d = vsm_out;
                    j_d      = '0;
                    state_d  = ST_OUT;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_OUT: begin
                y_valid = !reset;
                if (y_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign y_data = y_data_q;

endmodule
